// File: rtl/new_usb_ohci_pkg.sv
// Shared types for the OHCI endpoint-descriptor list scheduler.
package new_usb_ohci_pkg;

    localparam int ED_ADDR_W = 28;

    typedef enum logic [1:0] {
        LIST_NONE     = 2'd0,
        LIST_PERIODIC = 2'd1,
        LIST_CONTROL  = 2'd2,
        LIST_BULK     = 2'd3
    } ed_list_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SERVE = 2'd3
    } sched_state_e;

    function automatic logic [31:0] ed_fetch_addr(input logic [ED_ADDR_W-1:0] ptr);
        return {ptr, 4'b0000};
    endfunction

    // After the periodic list, go back to the interrupted list if it is still live.
    function automatic ed_list_e resume_list(input ed_list_e pref, input logic ctrl_ok,
                                             input logic bulk_ok);
        ed_list_e sel;
        if (pref == LIST_CONTROL && ctrl_ok) begin
            sel = LIST_CONTROL;
        end else if (pref == LIST_BULK && bulk_ok) begin
            sel = LIST_BULK;
        end else if (ctrl_ok) begin
            sel = LIST_CONTROL;
        end else if (bulk_ok) begin
            sel = LIST_BULK;
        end else begin
            sel = LIST_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/new_usb_edlistscheduler.sv
// OHCI ED list scheduler: picks periodic/control/bulk list, issues ED fetches
// to the DMA and signals context switches around the ED output queue.
module new_usb_edlistscheduler
    import new_usb_ohci_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sof_i,
    input  logic                 periodic_en_i,
    input  logic                 control_en_i,
    input  logic                 bulk_en_i,
    input  logic                 clf_i,
    input  logic                 blf_i,
    output logic                 clf_clear_o,
    output logic                 blf_clear_o,
    input  logic [1:0]           cbsr_i,
    input  logic [ED_ADDR_W-1:0] periodic_head_i,
    input  logic [ED_ADDR_W-1:0] control_head_i,
    input  logic [ED_ADDR_W-1:0] bulk_head_i,
    input  logic [ED_ADDR_W-1:0] ed_next_i,
    input  logic                 secondin_loaded_i,
    input  logic                 secondin_valid_i,
    input  logic                 empty_secondin_i,
    input  logic                 pop_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [31:0]          req_addr_o,
    output logic                 context_switch_np2p_o,
    output logic                 context_switch_p2np_o,
    output logic                 context_switch_o,
    output logic [1:0]           list_o,
    output logic                 frame_overrun_o
);

    sched_state_e         state_r, state_n;
    logic [ED_ADDR_W-1:0] ctrl_ptr_r, ctrl_ptr_n;
    logic [ED_ADDR_W-1:0] bulk_ptr_r, bulk_ptr_n;
    logic [ED_ADDR_W-1:0] per_ptr_r, per_ptr_n;
    logic                 ctrl_active_r, ctrl_active_n;
    logic                 bulk_active_r, bulk_active_n;
    logic [2:0]           ratio_cnt_r, ratio_cnt_n;
    ed_list_e             np_list_r, np_list_n;
    ed_list_e             list_r, list_n;
    logic                 stash_valid_r, stash_valid_n;
    logic                 sof_pend_r, sof_pend_n;
    logic                 req_valid_r, req_valid_n;
    logic [31:0]          req_addr_r, req_addr_n;
    logic                 clf_clear_r, clf_clear_n;
    logic                 blf_clear_r, blf_clear_n;
    logic                 np2p_r, np2p_n;
    logic                 p2np_r, p2np_n;
    logic                 cs_r;
    logic                 overrun_r, overrun_n;

    logic                 sof_evt_s;
    logic                 start_c_s;
    logic                 start_b_s;
    logic                 take_sof_s;
    logic                 advance_s;
    logic                 route_s;
    logic                 fetch_s;
    logic [ED_ADDR_W-1:0] fetch_ptr_s;
    logic                 ctrl_ok_s;
    logic                 bulk_ok_s;
    logic [2:0]           rc_s;
    ed_list_e             sel_s;

    // A frame start only matters when periodic work is enabled or already running.
    assign sof_evt_s = sof_i & (periodic_en_i | (list_r == LIST_PERIODIC));
    assign start_c_s = control_en_i & clf_i;
    assign start_b_s = bulk_en_i & blf_i;

    // Next-state computation for the list traversal sequencer
    always_comb begin
        state_n       = state_r;
        ctrl_ptr_n    = ctrl_ptr_r;
        bulk_ptr_n    = bulk_ptr_r;
        per_ptr_n     = per_ptr_r;
        ctrl_active_n = ctrl_active_r;
        bulk_active_n = bulk_active_r;
        ratio_cnt_n   = ratio_cnt_r;
        np_list_n     = np_list_r;
        list_n        = list_r;
        stash_valid_n = stash_valid_r;
        sof_pend_n    = sof_pend_r | sof_evt_s;
        req_valid_n   = req_valid_r;
        req_addr_n    = req_addr_r;
        clf_clear_n   = 1'b0;
        blf_clear_n   = 1'b0;
        np2p_n        = 1'b0;
        p2np_n        = 1'b0;
        overrun_n     = 1'b0;
        take_sof_s    = 1'b0;
        advance_s     = 1'b0;
        route_s       = 1'b0;
        fetch_s       = 1'b0;
        fetch_ptr_s   = {ED_ADDR_W{1'b0}};
        ctrl_ok_s     = 1'b0;
        bulk_ok_s     = 1'b0;
        rc_s          = ratio_cnt_r;
        sel_s         = LIST_NONE;

        case (state_r)
            ST_IDLE: begin
                if (sof_pend_n) begin
                    take_sof_s = 1'b1;
                end else if (start_c_s || start_b_s) begin
                    if (start_c_s) begin
                        ctrl_active_n = 1'b1;
                        clf_clear_n   = 1'b1;
                        ctrl_ptr_n    = control_head_i;
                    end else begin
                        ctrl_active_n = ctrl_active_r;
                    end
                    if (start_b_s) begin
                        bulk_active_n = 1'b1;
                        blf_clear_n   = 1'b1;
                        bulk_ptr_n    = bulk_head_i;
                    end else begin
                        bulk_active_n = bulk_active_r;
                    end
                    if (start_c_s) begin
                        sel_s       = LIST_CONTROL;
                        fetch_ptr_s = control_head_i;
                    end else begin
                        sel_s       = LIST_BULK;
                        fetch_ptr_s = bulk_head_i;
                    end
                    list_n    = sel_s;
                    np_list_n = sel_s;
                    fetch_s   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (req_ready_i) begin
                    req_valid_n = 1'b0;
                    state_n     = ST_WAIT;
                end else begin
                    req_valid_n = 1'b1;
                end
            end
            ST_WAIT: begin
                if (secondin_loaded_i) begin
                    if (sof_pend_n) begin
                        take_sof_s = 1'b1;
                    end else begin
                        state_n = ST_SERVE;
                    end
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_SERVE: begin
                if (pop_i || empty_secondin_i) begin
                    advance_s = 1'b1;
                end else if (sof_pend_n) begin
                    take_sof_s = 1'b1;
                end else begin
                    state_n = ST_SERVE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (advance_s) begin
            if (list_r == LIST_PERIODIC) begin
                per_ptr_n = ed_next_i;
                if (ed_next_i != {ED_ADDR_W{1'b0}}) begin
                    fetch_s     = 1'b1;
                    fetch_ptr_s = ed_next_i;
                end else begin
                    p2np_n        = 1'b1;
                    ctrl_ok_s     = ctrl_active_r & control_en_i;
                    bulk_ok_s     = bulk_active_r & bulk_en_i;
                    ctrl_active_n = ctrl_ok_s;
                    bulk_active_n = bulk_ok_s;
                    if (stash_valid_r) begin
                        // Queue re-presents the stashed nonperiodic ED; nothing to fetch.
                        stash_valid_n = 1'b0;
                        list_n        = np_list_r;
                        state_n       = ST_SERVE;
                    end else begin
                        sel_s   = resume_list(np_list_r, ctrl_ok_s, bulk_ok_s);
                        route_s = 1'b1;
                    end
                end
            end else begin
                ctrl_ok_s = ctrl_active_r;
                bulk_ok_s = bulk_active_r;
                if (list_r == LIST_CONTROL) begin
                    if (rc_s != 3'd7) begin
                        rc_s = rc_s + 3'd1;
                    end else begin
                        rc_s = 3'd7;
                    end
                    if (ed_next_i != {ED_ADDR_W{1'b0}}) begin
                        ctrl_ptr_n = ed_next_i;
                    end else begin
                        ctrl_ptr_n = control_head_i;
                        if (clf_i) begin
                            clf_clear_n = 1'b1;
                        end else begin
                            ctrl_ok_s = 1'b0;
                        end
                    end
                end else if (list_r == LIST_BULK) begin
                    if (ed_next_i != {ED_ADDR_W{1'b0}}) begin
                        bulk_ptr_n = ed_next_i;
                    end else begin
                        bulk_ptr_n = bulk_head_i;
                        if (blf_i) begin
                            blf_clear_n = 1'b1;
                        end else begin
                            bulk_ok_s = 1'b0;
                        end
                    end
                end else begin
                    rc_s = ratio_cnt_r;
                end
                ctrl_ok_s     = ctrl_ok_s & control_en_i;
                bulk_ok_s     = bulk_ok_s & bulk_en_i;
                ctrl_active_n = ctrl_ok_s;
                bulk_active_n = bulk_ok_s;
                if ((rc_s > {1'b0, cbsr_i}) && bulk_ok_s) begin
                    sel_s = LIST_BULK;
                    rc_s  = 3'd0;
                end else if (ctrl_ok_s) begin
                    sel_s = LIST_CONTROL;
                end else if (bulk_ok_s) begin
                    sel_s = LIST_BULK;
                end else begin
                    sel_s = LIST_NONE;
                end
                ratio_cnt_n = rc_s;
                route_s     = 1'b1;
            end
        end else begin
            route_s = 1'b0;
        end

        if (route_s) begin
            list_n = sel_s;
            case (sel_s)
                LIST_CONTROL: begin
                    fetch_s     = 1'b1;
                    fetch_ptr_s = ctrl_ptr_n;
                    np_list_n   = LIST_CONTROL;
                end
                LIST_BULK: begin
                    fetch_s     = 1'b1;
                    fetch_ptr_s = bulk_ptr_n;
                    np_list_n   = LIST_BULK;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else begin
            list_n = list_n;
        end

        if (take_sof_s) begin
            sof_pend_n = 1'b0;
            if (list_r == LIST_PERIODIC) begin
                overrun_n = 1'b1;
            end else begin
                np2p_n        = 1'b1;
                stash_valid_n = secondin_valid_i;
            end
            per_ptr_n   = periodic_head_i;
            list_n      = LIST_PERIODIC;
            fetch_s     = 1'b1;
            fetch_ptr_s = periodic_head_i;
        end else begin
            sof_pend_n = sof_pend_n;
        end

        // A pending frame start wins over a freshly selected nonperiodic fetch.
        if (fetch_s) begin
            if (sof_pend_n) begin
                state_n = ST_IDLE;
            end else begin
                state_n     = ST_FETCH;
                req_valid_n = 1'b1;
                req_addr_n  = ed_fetch_addr(fetch_ptr_s);
            end
        end else begin
            req_addr_n = req_addr_r;
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            ctrl_ptr_r    <= {ED_ADDR_W{1'b0}};
            bulk_ptr_r    <= {ED_ADDR_W{1'b0}};
            per_ptr_r     <= {ED_ADDR_W{1'b0}};
            ctrl_active_r <= 1'b0;
            bulk_active_r <= 1'b0;
            ratio_cnt_r   <= 3'd0;
            np_list_r     <= LIST_NONE;
            list_r        <= LIST_NONE;
            stash_valid_r <= 1'b0;
            sof_pend_r    <= 1'b0;
            req_valid_r   <= 1'b0;
            req_addr_r    <= 32'd0;
            clf_clear_r   <= 1'b0;
            blf_clear_r   <= 1'b0;
            np2p_r        <= 1'b0;
            p2np_r        <= 1'b0;
            cs_r          <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            state_r       <= state_n;
            ctrl_ptr_r    <= ctrl_ptr_n;
            bulk_ptr_r    <= bulk_ptr_n;
            per_ptr_r     <= per_ptr_n;
            ctrl_active_r <= ctrl_active_n;
            bulk_active_r <= bulk_active_n;
            ratio_cnt_r   <= ratio_cnt_n;
            np_list_r     <= np_list_n;
            list_r        <= list_n;
            stash_valid_r <= stash_valid_n;
            sof_pend_r    <= sof_pend_n;
            req_valid_r   <= req_valid_n;
            req_addr_r    <= req_addr_n;
            clf_clear_r   <= clf_clear_n;
            blf_clear_r   <= blf_clear_n;
            np2p_r        <= np2p_n;
            p2np_r        <= p2np_n;
            cs_r          <= np2p_n | p2np_n;
            overrun_r     <= overrun_n;
        end
    end

    assign clf_clear_o           = clf_clear_r;
    assign blf_clear_o           = blf_clear_r;
    assign req_valid_o           = req_valid_r;
    assign req_addr_o            = req_addr_r;
    assign context_switch_np2p_o = np2p_r;
    assign context_switch_p2np_o = p2np_r;
    assign context_switch_o      = cs_r;
    assign list_o                = list_r;
    assign frame_overrun_o       = overrun_r;

endmodule

// File: tb/tb_new_usb_edlistscheduler.sv
// Directed bench for the ED list scheduler; the bench plays DMA, ED queue and HCD.
module tb_new_usb_edlistscheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sof_i, periodic_en_i, control_en_i, bulk_en_i, clf_i, blf_i;
    logic        clf_clear_o, blf_clear_o;
    logic [1:0]  cbsr_i;
    logic [27:0] periodic_head_i, control_head_i, bulk_head_i, ed_next_i;
    logic        secondin_loaded_i, secondin_valid_i, empty_secondin_i, pop_i;
    logic        req_valid_o, req_ready_i;
    logic [31:0] req_addr_o;
    logic        context_switch_np2p_o, context_switch_p2np_o, context_switch_o;
    logic [1:0]  list_o;
    logic        frame_overrun_o;

    int n_checks = 0;
    int n_bad    = 0;
    logic np2p_seen;

    always #5 clk_i = ~clk_i;

    new_usb_edlistscheduler dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .sof_i                 (sof_i),
        .periodic_en_i         (periodic_en_i),
        .control_en_i          (control_en_i),
        .bulk_en_i             (bulk_en_i),
        .clf_i                 (clf_i),
        .blf_i                 (blf_i),
        .clf_clear_o           (clf_clear_o),
        .blf_clear_o           (blf_clear_o),
        .cbsr_i                (cbsr_i),
        .periodic_head_i       (periodic_head_i),
        .control_head_i        (control_head_i),
        .bulk_head_i           (bulk_head_i),
        .ed_next_i             (ed_next_i),
        .secondin_loaded_i     (secondin_loaded_i),
        .secondin_valid_i      (secondin_valid_i),
        .empty_secondin_i      (empty_secondin_i),
        .pop_i                 (pop_i),
        .req_valid_o           (req_valid_o),
        .req_ready_i           (req_ready_i),
        .req_addr_o            (req_addr_o),
        .context_switch_np2p_o (context_switch_np2p_o),
        .context_switch_p2np_o (context_switch_p2np_o),
        .context_switch_o      (context_switch_o),
        .list_o                (list_o),
        .frame_overrun_o       (frame_overrun_o)
    );

    task automatic check_sig(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sof_i = 1'b0; periodic_en_i = 1'b0; control_en_i = 1'b0; bulk_en_i = 1'b0;
        clf_i = 1'b0; blf_i = 1'b0; cbsr_i = 2'd0;
        periodic_head_i = 28'h0000300; control_head_i = 28'h0000100; bulk_head_i = 28'h0000200;
        ed_next_i = 28'd0; secondin_loaded_i = 1'b0; secondin_valid_i = 1'b0;
        empty_secondin_i = 1'b0; pop_i = 1'b0; req_ready_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Wait for a fetch, check it, then accept, load and pop the ED with the given nextED.
    task automatic do_ed(input string tag, input logic [31:0] exp_addr, input logic [1:0] exp_list,
                         input logic [27:0] nxt);
        int n;
        n = 0;
        while (!req_valid_o && n < 40) begin
            tick();
            n++;
        end
        check_sig({tag, "_vld"}, {31'd0, req_valid_o}, 32'd1);
        check_sig({tag, "_addr"}, req_addr_o, exp_addr);
        check_sig({tag, "_list"}, {30'd0, list_o}, {30'd0, exp_list});
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        secondin_loaded_i = 1'b1; tick(); secondin_loaded_i = 1'b0;
        ed_next_i = nxt; pop_i = 1'b1; tick(); pop_i = 1'b0;
    endtask

    initial begin
        // Reset values and single control ED, request held until accepted
        do_reset();
        check_sig("rst_vld", {31'd0, req_valid_o}, 32'd0);
        check_sig("rst_list", {30'd0, list_o}, 32'd0);
        check_sig("rst_cs", {29'd0, context_switch_o, context_switch_np2p_o, context_switch_p2np_o}, 32'd0);
        check_sig("rst_addr", req_addr_o, 32'd0);
        control_head_i = 28'h0001000;
        control_en_i = 1'b1; clf_i = 1'b1;
        tick();
        clf_i = 1'b0;
        check_sig("t1_clfclr", {31'd0, clf_clear_o}, 32'd1);
        check_sig("t1_addr", req_addr_o, 32'h00010000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_sig("t1_hold_addr", req_addr_o, 32'h00010000);
            check_sig("t1_hold_vld", {31'd0, req_valid_o}, 32'd1);
        end
        check_sig("t1_clfclr_once", {31'd0, clf_clear_o}, 32'd0);
        do_ed("t1_c0", 32'h00010000, 2'd2, 28'd0);
        tick();
        check_sig("t1_idle_vld", {31'd0, req_valid_o}, 32'd0);
        check_sig("t1_idle_list", {30'd0, list_o}, 32'd0);

        // Control:bulk 2:1 interleave, then control drains and bulk runs alone
        do_reset();
        cbsr_i = 2'd1; control_en_i = 1'b1; bulk_en_i = 1'b1; clf_i = 1'b1; blf_i = 1'b1;
        tick();
        clf_i = 1'b0; blf_i = 1'b0;
        check_sig("t2_clfclr", {31'd0, clf_clear_o}, 32'd1);
        check_sig("t2_blfclr", {31'd0, blf_clear_o}, 32'd1);
        do_ed("t2_c1", 32'h00001000, 2'd2, 28'h0000110);
        do_ed("t2_c2", 32'h00001100, 2'd2, 28'h0000120);
        do_ed("t2_b1", 32'h00002000, 2'd3, 28'h0000210);
        clf_i = 1'b1;
        do_ed("t2_c3", 32'h00001200, 2'd2, 28'd0);
        check_sig("t2_c3_clfclr", {31'd0, clf_clear_o}, 32'd1);
        clf_i = 1'b0;
        do_ed("t2_c1b", 32'h00001000, 2'd2, 28'h0000110);
        do_ed("t2_b2", 32'h00002100, 2'd3, 28'h0000220);
        do_ed("t2_c2b", 32'h00001100, 2'd2, 28'h0000120);
        do_ed("t2_c3b", 32'h00001200, 2'd2, 28'd0);
        check_sig("t3_clfclr", {31'd0, clf_clear_o}, 32'd0);
        do_ed("t3_b3", 32'h00002200, 2'd3, 28'h0000230);
        do_ed("t3_b4", 32'h00002300, 2'd3, 28'd0);
        check_sig("t3_blfclr", {31'd0, blf_clear_o}, 32'd0);
        check_sig("t3_list", {30'd0, list_o}, 32'd0);
        tick();
        check_sig("t3_idle_vld", {31'd0, req_valid_o}, 32'd0);

        // Frame start with a queued nonperiodic ED, periodic list, restore without fetch
        do_reset();
        periodic_en_i = 1'b1; control_en_i = 1'b1; clf_i = 1'b1;
        tick();
        clf_i = 1'b0;
        check_sig("t4_addr", req_addr_o, 32'h00001000);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        secondin_loaded_i = 1'b1; tick(); secondin_loaded_i = 1'b0;
        secondin_valid_i = 1'b1; sof_i = 1'b1; tick(); sof_i = 1'b0; secondin_valid_i = 1'b0;
        check_sig("t4_np2p", {31'd0, context_switch_np2p_o}, 32'd1);
        check_sig("t4_cs", {31'd0, context_switch_o}, 32'd1);
        check_sig("t4_p2np_lo", {31'd0, context_switch_p2np_o}, 32'd0);
        tick();
        check_sig("t4_np2p_pulse", {31'd0, context_switch_np2p_o}, 32'd0);
        do_ed("t4_p1", 32'h00003000, 2'd1, 28'h0000310);
        do_ed("t4_p2", 32'h00003100, 2'd1, 28'd0);
        check_sig("t4_p2np", {31'd0, context_switch_p2np_o}, 32'd1);
        check_sig("t4_cs2", {31'd0, context_switch_o}, 32'd1);
        check_sig("t4_ret_list", {30'd0, list_o}, 32'd2);
        check_sig("t4_nofetch", {31'd0, req_valid_o}, 32'd0);
        ed_next_i = 28'h0000110; pop_i = 1'b1; tick(); pop_i = 1'b0;
        check_sig("t4_resume_addr", req_addr_o, 32'h00001100);
        check_sig("t4_resume_vld", {31'd0, req_valid_o}, 32'd1);

        // Frame start while the periodic list is still running
        do_reset();
        periodic_en_i = 1'b1;
        sof_i = 1'b1; tick(); sof_i = 1'b0;
        check_sig("t5_np2p", {31'd0, context_switch_np2p_o}, 32'd1);
        do_ed("t5_p1", 32'h00003000, 2'd1, 28'h0000310);
        check_sig("t5_p2_addr", req_addr_o, 32'h00003100);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        secondin_loaded_i = 1'b1; tick(); secondin_loaded_i = 1'b0;
        sof_i = 1'b1; tick(); sof_i = 1'b0;
        check_sig("t5_overrun", {31'd0, frame_overrun_o}, 32'd1);
        check_sig("t5_no_np2p", {31'd0, context_switch_np2p_o}, 32'd0);
        check_sig("t5_no_cs", {31'd0, context_switch_o}, 32'd0);
        tick();
        check_sig("t5_overrun_pulse", {31'd0, frame_overrun_o}, 32'd0);
        do_ed("t5_p1b", 32'h00003000, 2'd1, 28'd0);
        check_sig("t5_p2np", {31'd0, context_switch_p2np_o}, 32'd1);
        check_sig("t5_end_list", {30'd0, list_o}, 32'd0);
        check_sig("t5_end_vld", {31'd0, req_valid_o}, 32'd0);

        // Frame start while a control fetch waits for the DMA
        do_reset();
        periodic_en_i = 1'b1; control_en_i = 1'b1; clf_i = 1'b1;
        tick();
        clf_i = 1'b0;
        np2p_seen = 1'b0;
        sof_i = 1'b1; tick(); sof_i = 1'b0;
        np2p_seen = np2p_seen | context_switch_np2p_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            np2p_seen = np2p_seen | context_switch_np2p_o;
        end
        check_sig("t6_hold_addr", req_addr_o, 32'h00001000);
        check_sig("t6_hold_vld", {31'd0, req_valid_o}, 32'd1);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        np2p_seen = np2p_seen | context_switch_np2p_o;
        check_sig("t6_np2p_early", {31'd0, np2p_seen}, 32'd0);
        secondin_valid_i = 1'b1; secondin_loaded_i = 1'b1; tick();
        secondin_loaded_i = 1'b0; secondin_valid_i = 1'b0;
        check_sig("t6_np2p", {31'd0, context_switch_np2p_o}, 32'd1);
        check_sig("t6_p_addr", req_addr_o, 32'h00003000);
        check_sig("t6_p_list", {30'd0, list_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
